// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder sequencer.
package serial_add_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Shift counter must be able to hold WIDTH itself after the final increment.
    function automatic int cnt_w_of(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_add_check.sv
// Parallel reference adder with a sticky mismatch flag.
// Instantiated by serial_add_ctrl only when SERIAL_ADD_CTRL_SELFCHECK_EN is defined.
module serial_add_check
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             check_en,
    input  logic [WIDTH-1:0] a_q,
    input  logic [WIDTH-1:0] b_q,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             carry_q,
    output logic             err
);

    logic [WIDTH:0] ref_sum;

    assign ref_sum = {1'b0, a_q} + {1'b0, b_q};

    // check_en marks the edge that captures the sum, so the compare sees
    // exactly the value that lands in sum_q when DONE is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (check_en && (ref_sum != {carry_q, add_sum})) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the WIDTH-bit serial adder: accept operands, load the adder,
// count the shift cycles, capture sum and carry, hold the result until taken.
// Optional build macro: SERIAL_ADD_CTRL_SELFCHECK_EN (parallel reference check on err).
//
// state   | meaning
// IDLE    | ready for an operand pair
// LOAD    | add_load high; next edge loads the adder
// SHIFT   | adder shifting; final carry captured on the last shift edge
// CAPTURE | adder sum register complete; next edge captures it and flushes carry
// DONE    | result presented until out_ready
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             add_load,
    output logic [WIDTH-1:0] add_in1,
    output logic [WIDTH-1:0] add_in2,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_carry,
    output logic             err
);

    localparam int               CNT_W    = cnt_w_of(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; CAPTURE is always one cycle so the adder carry flop
    // shifts in zeros once more before any later load.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (count == CNT_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, shift counter and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (in_valid) begin
                        a_q <= a_in;
                        b_q <= b_in;
                    end
                end
                LOAD: count <= '0;
                SHIFT: begin
                    count <= count + CNT_ONE;
                    if (count == CNT_LAST) begin
                        carry_q <= add_carry;
                    end
                end
                CAPTURE: sum_q <= add_sum;
                default: ;
            endcase
        end
    end

    // Moore outputs, decoded from registered state only.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        add_load  = (state == LOAD);
    end

    assign add_in1   = a_q;
    assign add_in2   = b_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;

`ifdef SERIAL_ADD_CTRL_SELFCHECK_EN
    serial_add_check #(
        .WIDTH (WIDTH)
    ) u_check (
        .clk      (clk),
        .reset    (reset),
        .check_en (state == CAPTURE),
        .a_q      (a_q),
        .b_q      (b_q),
        .add_sum  (add_sum),
        .carry_q  (carry_q),
        .err      (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule
